multirotor_mixer: RTL
=====================

# multirotor_mixer

Parametrised successor to the four-motor flight-controller datapath. It takes decoded pilot commands (throttle, pitch, roll, yaw) and mixes them through a per-motor signed coefficient table, one motor per cycle. Each motor command is saturated, and all commands drive NUM_MOTORS PWM outputs that update without glitches. It adds an arming state machine and a command-loss failsafe, and sits between the receiver readers and the motors.

## Interface
- NUM_MOTORS, 4, number of motor channels (2..8)
- CMD_W, 8, command and duty width; PWM period = 2^CMD_W clocks
- COEF_W, 4, signed coefficient width; units of 1/4
- MIX_COEF, X-quad table, NUM_MOTORS*3*COEF_W flat, per motor {yaw, roll, pitch} with motor 0 in the LSBs
  - Default: M0 (+4,−4,+4), M1 (+4,+4,−4), M2 (−4,+4,+4), M3 (−4,−4,−4), each written as (pitch, roll, yaw)
- IDLE_CMD, 8, minimum command while armed
- ARM_THR_MAX, 16, highest throttle at which arming is accepted
- FAILSAFE_CYCLES, 1_000_000, clocks without cmd_valid before failsafe
- clk  in  1  system clock, single domain
- rst_n  in  1  asynchronous, active-low reset
- throttle  in  CMD_W  unsigned throttle
- pitch, roll, yaw  in  CMD_W each  signed two's-complement attitude commands, 0 = centre
- cmd_valid  in  1  one-cycle strobe: command inputs are valid
- arm_req  in  1  level, pilot arm switch
- motor_pwm  out  NUM_MOTORS  PWM per motor
- motor_cmd  out  NUM_MOTORS*CMD_W  active duty registers, motor 0 in the LSBs
- armed  out  1  high in ARMED
- failsafe  out  1  high in FAILSAFE

## Operation
- **Reset values:** every output 0; FSM in DISARMED; sequencer idle; PWM counter 0; watchdog 0.
- **Input capture:** on cmd_valid, all four inputs are captured and the watchdog clears. If the sequencer is busy, the capture still updates but no new pass starts; the busy-time strobe is dropped for mixing.
- **Mixing pass:** starts the cycle after a cmd_valid accepted while idle, then handles motor k on pass cycle k.
  - a = cp·pitch + cr·roll + cy·yaw, signed, CMD_W+COEF_W+2 bits.
  - s = (a >>> 2) + zero-extended throttle. The shift is arithmetic (floor).
  - If armed, clamp s to [IDLE_CMD, 2^CMD_W−1]. Otherwise the result is 0.
  - The result is written to shadow[k].
  - After the last motor, commit_pending is set.
- **Commit:** at PWM wrap (counter 2^CMD_W−1 → 0), if commit_pending, all shadows load into the active registers together and commit_pending clears.
- **Immediate zeroing:** leaving ARMED (disarm or failsafe) zeroes the active and shadow registers at once, without waiting for wrap, and clears commit_pending.
- **PWM:** one shared free-running counter. motor_pwm[k] = (counter < active[k]). Duty 0 stays constantly low; duty 255 is high for 255 of 256 clocks.
- **FSM:**
  - DISARMED → ARMED on cmd_valid with arm_req=1 and throttle ≤ ARM_THR_MAX. Arming with higher throttle is refused.
  - ARMED → DISARMED when arm_req=0.
  - ARMED → FAILSAFE when the watchdog reaches FAILSAFE_CYCLES.
  - FAILSAFE → DISARMED on cmd_valid with arm_req=0. No direct re-arm.
  - The watchdog counts in every state and saturates; it affects state only in ARMED.
- **Simultaneous events:**
  - cmd_valid on the timeout cycle: cmd_valid wins and the watchdog clears.
  - Disarm during a pass: the pass finishes but writes zeros, because the armed check is evaluated per motor.
- **Reset mid-pass:** everything returns to reset values immediately.

## Timing
- cmd_valid sampled at edge t → motor k computed at edge t+1+k → commit_pending at t+NUM_MOTORS → active update at the first wrap after that.
- Worst-case latency from cmd_valid to new duty: NUM_MOTORS + 2^CMD_W clocks.
- armed/failsafe change one clock after the qualifying edge. Forced zero duty is visible on motor_pwm on the following clock.
- No combinational path from any input to any output.

## Structure
- Package mixer_pkg holds:
  - the FSM state enum {DISARMED, ARMED, FAILSAFE};
  - the default X-quad coefficient constant;
  - a saturating clamp function.
- Sub-module mixer_pwm_out holds the shared counter, the active registers with their wrap-commit and force-zero logic, and the comparators. It takes NUM_MOTORS and CMD_W as parameters.
- The top level holds input capture, the sequencer/datapath (one multiply-accumulate, time-shared), the watchdog and the FSM.

## Test plan
- **Reset:** assert rst_n=0 mid-PWM-period → all motor_pwm, motor_cmd, armed and failsafe are 0 asynchronously, and stay 0 after release with no cmd_valid.
- **Arming:** arm_req=1, throttle=10, attitude 0, cmd_valid → armed=1 next clock, all motor_cmd=10 after wrap. Throttle=4 gives 8 (idle clamp). Throttle=20 while disarmed → armed stays 0.
- **Mixing:** armed, throttle=100, pitch=20 → M0=M1=120, M2=M3=80. Yaw=−8, others 0 with throttle=100 → M0=M2=92, M1=M3=108.
- **Saturation:** throttle=250, pitch=20 → M0=M1=255, M2=M3=230. Throttle=10, pitch=−100 → M0=M1=8 (clamp), M2=M3=110.
- **Failsafe:** FAILSAFE_CYCLES=1000, armed at throttle=100, cmd_valid stops → at 1000 clocks failsafe=1, armed=0, motor_cmd=0 immediately. A cmd_valid with arm_req=1 keeps FAILSAFE; arm_req=0 plus cmd_valid gives DISARMED.
- **Glitch-free update:** duty 64 active, new command 200 mixed mid-period → current period shows exactly 64 high clocks, the next period shows exactly 200 high clocks.

Source files
------------

// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared FSM type, default X-quad mixing table and clamp helper
// Contents:
//   fsm_state_t  : arming state machine encoding
//   X_QUAD_COEF  : default 4-motor table, per motor {yaw, roll, pitch}, motor 0 in LSBs
//   sat_clamp()  : saturate an integer into [lo, hi]
package mixer_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    FAILSAFE = 2'd2
  } fsm_state_t;

  // Coefficients are signed 4-bit in units of 1/4: 4'h4 = +1.0, 4'hC = -1.0.
  // M0 (p+,r-,y+), M1 (p+,r+,y-), M2 (p-,r+,y+), M3 (p-,r-,y-).
  localparam logic [47:0] X_QUAD_COEF = {12'hCCC, 12'h44C, 12'hC44, 12'h4C4};

  function automatic int sat_clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/mixer_pwm_out.sv
// rtl/mixer_pwm_out.sv - shared PWM counter, wrap-committed duty registers, comparators
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   shadow      : NUM_MOTORS*CMD_W staged duties from the mixer, motor 0 in LSBs
//   pass_done   : pulse, all shadows of a mixing pass are written
//   force_zero  : pulse, drop every active duty to 0 now and cancel a pending commit
//   active      : NUM_MOTORS*CMD_W duties currently driving the comparators
//   pwm         : NUM_MOTORS registered PWM outputs
module mixer_pwm_out #(
  parameter int NUM_MOTORS = 4,
  parameter int CMD_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MOTORS*CMD_W-1:0] shadow,
  input  logic                        pass_done,
  input  logic                        force_zero,
  output logic [NUM_MOTORS*CMD_W-1:0] active,
  output logic [NUM_MOTORS-1:0]       pwm
);

  logic [CMD_W-1:0] counter;
  logic             commit_pending;
  logic             wrap;

  assign wrap = (counter == {CMD_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) counter <= '0;
    else        counter <= counter + 1'b1;
  end

  // Duties only change on the wrap edge so no period is ever cut short or stretched;
  // force_zero is the one exception and takes priority over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active         <= '0;
      commit_pending <= 1'b0;
    end else if (force_zero) begin
      active         <= '0;
      commit_pending <= 1'b0;
    end else begin
      if (wrap && commit_pending) begin
        active         <= shadow;
        commit_pending <= 1'b0;
      end
      if (pass_done) commit_pending <= 1'b1;
    end
  end

  // Registered compare keeps the motor pins free of comparator glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= '0;
    end else begin
      for (int k = 0; k < NUM_MOTORS; k++) pwm[k] <= (counter < active[k*CMD_W +: CMD_W]);
    end
  end

endmodule

// File: rtl/multirotor_mixer.sv
// rtl/multirotor_mixer.sv - pilot command mixer with arming FSM, failsafe watchdog and PWM outputs
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   throttle                 : CMD_W unsigned throttle
//   pitch, roll, yaw         : CMD_W signed attitude commands, 0 = centre
//   cmd_valid                : one-cycle strobe, command inputs valid
//   arm_req                  : level, pilot arm switch
//   motor_pwm                : NUM_MOTORS PWM outputs
//   motor_cmd                : NUM_MOTORS*CMD_W active duties, motor 0 in LSBs
//   armed, failsafe          : FSM state flags
module multirotor_mixer
  import mixer_pkg::*;
#(
  parameter int                              NUM_MOTORS      = 4,
  parameter int                              CMD_W           = 8,
  parameter int                              COEF_W          = 4,
  parameter logic [NUM_MOTORS*3*COEF_W-1:0] MIX_COEF        = X_QUAD_COEF,
  parameter int                              IDLE_CMD        = 8,
  parameter int                              ARM_THR_MAX     = 16,
  parameter int                              FAILSAFE_CYCLES = 1_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CMD_W-1:0]            throttle,
  input  logic [CMD_W-1:0]            pitch,
  input  logic [CMD_W-1:0]            roll,
  input  logic [CMD_W-1:0]            yaw,
  input  logic                        cmd_valid,
  input  logic                        arm_req,
  output logic [NUM_MOTORS-1:0]       motor_pwm,
  output logic [NUM_MOTORS*CMD_W-1:0] motor_cmd,
  output logic                        armed,
  output logic                        failsafe
);

  localparam int ACC_W   = CMD_W + COEF_W + 2;
  localparam int IDX_W   = $clog2(NUM_MOTORS);
  localparam int WD_W    = $clog2(FAILSAFE_CYCLES + 1);
  localparam int CMD_MAX = (1 << CMD_W) - 1;

  fsm_state_t                  state, state_nx;
  logic [WD_W-1:0]             wdog;
  logic                        wd_expired;
  logic [CMD_W-1:0]            cap_thr, cap_pitch, cap_roll, cap_yaw;
  logic                        busy;
  logic [IDX_W-1:0]            idx;
  logic [NUM_MOTORS*CMD_W-1:0] shadow;
  logic                        pass_done;
  logic                        leave_armed;
  logic [COEF_W-1:0]           cp, cr, cy;
  logic signed [ACC_W-1:0]     ecp, ecr, ecy, ep, er, ey;
  logic signed [ACC_W-1:0]     acc, acc_q4, sum;
  logic [CMD_W-1:0]            duty;

  // ---------------- input capture and watchdog ----------------
  assign wd_expired = (wdog == WD_W'(FAILSAFE_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_thr   <= '0;
      cap_pitch <= '0;
      cap_roll  <= '0;
      cap_yaw   <= '0;
      wdog      <= '0;
    end else begin
      if (cmd_valid) begin
        cap_thr   <= throttle;
        cap_pitch <= pitch;
        cap_roll  <= roll;
        cap_yaw   <= yaw;
        wdog      <= '0;
      end else if (!wd_expired) begin
        wdog <= wdog + 1'b1;
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DISARMED;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DISARMED: if (cmd_valid && arm_req && (int'(throttle) <= ARM_THR_MAX)) state_nx = ARMED;
      ARMED: begin
        if (!arm_req)                     state_nx = DISARMED;
        else if (wd_expired && !cmd_valid) state_nx = FAILSAFE;
      end
      FAILSAFE: if (cmd_valid && !arm_req) state_nx = DISARMED;
      default:  state_nx = DISARMED;
    endcase
  end

  assign leave_armed = (state == ARMED) && (state_nx != ARMED);
  assign armed       = (state == ARMED);
  assign failsafe    = (state == FAILSAFE);

  // ---------------- time-shared mix datapath (motor idx) ----------------
  always_comb begin
    cp  = MIX_COEF[int'(idx)*3*COEF_W            +: COEF_W];
    cr  = MIX_COEF[int'(idx)*3*COEF_W + COEF_W   +: COEF_W];
    cy  = MIX_COEF[int'(idx)*3*COEF_W + 2*COEF_W +: COEF_W];
    ecp = {{(ACC_W-COEF_W){cp[COEF_W-1]}}, cp};
    ecr = {{(ACC_W-COEF_W){cr[COEF_W-1]}}, cr};
    ecy = {{(ACC_W-COEF_W){cy[COEF_W-1]}}, cy};
    ep  = {{(ACC_W-CMD_W){cap_pitch[CMD_W-1]}}, cap_pitch};
    er  = {{(ACC_W-CMD_W){cap_roll[CMD_W-1]}}, cap_roll};
    ey  = {{(ACC_W-CMD_W){cap_yaw[CMD_W-1]}}, cap_yaw};
    acc = ecp*ep + ecr*er + ecy*ey;
    // Kept as its own step so the shift stays in a signed (arithmetic, floor) context.
    acc_q4 = acc >>> 2;
    sum    = acc_q4 + {{(ACC_W-CMD_W){1'b0}}, cap_thr};
    // Armed is checked per motor, so a disarm mid-pass zeroes the remaining motors.
    duty   = (state == ARMED) ? CMD_W'(sat_clamp(int'(sum), IDLE_CMD, CMD_MAX)) : '0;
  end

  assign pass_done = busy && (idx == IDX_W'(NUM_MOTORS - 1));

  // A cmd_valid arriving while busy only refreshes the capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      idx    <= '0;
      shadow <= '0;
    end else begin
      if (busy) begin
        shadow[int'(idx)*CMD_W +: CMD_W] <= duty;
        if (pass_done) begin
          busy <= 1'b0;
          idx  <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (cmd_valid) begin
        busy <= 1'b1;
        idx  <= '0;
      end
      if (leave_armed) shadow <= '0;
    end
  end

  mixer_pwm_out #(
    .NUM_MOTORS (NUM_MOTORS),
    .CMD_W      (CMD_W)
  ) u_pwm_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .shadow     (shadow),
    .pass_done  (pass_done),
    .force_zero (leave_armed),
    .active     (motor_cmd),
    .pwm        (motor_pwm)
  );

endmodule
